alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. The winning command is latched onto the ALU
// inputs, and the ALU outputs are captured one cycle later into a valid/ready response tagged with the requester id.
module alu_share_arbiter #(
  parameter int unsigned FAIR = 32'd1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  input  logic [2:0]  i_req0_opsel,
  input  logic        i_req0_sub,
  input  logic        i_req0_unsigned,
  input  logic        i_req0_arith,
  input  logic [31:0] i_req0_op1,
  input  logic [31:0] i_req0_op2,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [2:0]  i_req1_opsel,
  input  logic        i_req1_sub,
  input  logic        i_req1_unsigned,
  input  logic        i_req1_arith,
  input  logic [31:0] i_req1_op1,
  input  logic [31:0] i_req1_op2,
  output logic        o_req1_ready,
  output logic [2:0]  o_alu_opsel,
  output logic        o_alu_sub,
  output logic        o_alu_unsigned,
  output logic        o_alu_arith,
  output logic [31:0] o_alu_op1,
  output logic [31:0] o_alu_op2,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_eq,
  input  logic        i_alu_slt,
  output logic        o_rsp_valid,
  output logic        o_rsp_id,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_eq,
  output logic        o_rsp_slt,
  input  logic        i_rsp_ready,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        id;
  } cmd_t;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        eq;
    logic        slt;
  } rsp_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int RSP_W = $bits(rsp_t);

  state_e state_q, state_d;
  logic   last_id_q, last_id_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   busy_q, busy_d;

  cmd_t   req0_cmd_s, req1_cmd_s;
  logic   rsp_hs_s;
  logic   grant_ok_s;
  logic   tie_win1_s;
  logic   grant0_s, grant1_s, grant_any_s;

  assign req0_cmd_s = '{opsel: i_req0_opsel, sub: i_req0_sub, uns: i_req0_unsigned,
                        arith: i_req0_arith, op1: i_req0_op1, op2: i_req0_op2, id: 1'b0};
  assign req1_cmd_s = '{opsel: i_req1_opsel, sub: i_req1_sub, uns: i_req1_unsigned,
                        arith: i_req1_arith, op1: i_req1_op1, op2: i_req1_op2, id: 1'b1};

  // Grant decode; reset gates it so both readys read low while reset is held
  always_comb begin
    rsp_hs_s   = rsp_valid_q && i_rsp_ready;
    grant_ok_s = i_rst_n && ((state_q == ST_IDLE) || rsp_hs_s);
    if (FAIR != 32'd0) begin
      tie_win1_s = ~last_id_q;
    end else begin
      tie_win1_s = 1'b0;
    end
    grant0_s    = grant_ok_s && i_req0_valid && (!i_req1_valid || !tie_win1_s);
    grant1_s    = grant_ok_s && i_req1_valid && (!i_req0_valid || tie_win1_s);
    grant_any_s = grant0_s || grant1_s;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_hs_s) begin
          if (grant_any_s) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command register and arbitration history
  always_comb begin
    cmd_d     = cmd_q;
    last_id_d = last_id_q;
    if (grant_any_s) begin
      if (grant1_s) begin
        cmd_d = req1_cmd_s;
      end else begin
        cmd_d = req0_cmd_s;
      end
      last_id_d = grant1_s;
    end else begin
      cmd_d     = cmd_q;
      last_id_d = last_id_q;
    end
  end

  // Response capture while the ALU evaluates the latched command
  always_comb begin
    rsp_d = rsp_q;
    if (state_q == ST_EXEC) begin
      rsp_d = '{id: cmd_q.id, result: i_alu_result, eq: i_alu_eq, slt: i_alu_slt};
    end else begin
      rsp_d = rsp_q;
    end
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // State registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      last_id_q   <= 1'b1;
      cmd_q       <= {CMD_W{1'b0}};
      rsp_q       <= {RSP_W{1'b0}};
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_req0_ready   = grant0_s;
  assign o_req1_ready   = grant1_s;
  assign o_alu_opsel    = cmd_q.opsel;
  assign o_alu_sub      = cmd_q.sub;
  assign o_alu_unsigned = cmd_q.uns;
  assign o_alu_arith    = cmd_q.arith;
  assign o_alu_op1      = cmd_q.op1;
  assign o_alu_op2      = cmd_q.op2;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_id       = rsp_q.id;
  assign o_rsp_result   = rsp_q.result;
  assign o_rsp_eq       = rsp_q.eq;
  assign o_rsp_slt      = rsp_q.slt;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench: instance 0 is round-robin, instance 1 fixed priority; both share a behavioural ALU model and
// are checked every cycle against a transaction-level reference plus directed spot checks.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic        valid;
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  req_t        rq [2][2];
  logic        rsp_ready [2];
  logic        rdy0 [2], rdy1 [2];
  logic [2:0]  a_opsel [2];
  logic        a_sub [2], a_uns [2], a_arith [2];
  logic [31:0] a_op1 [2], a_op2 [2];
  logic [31:0] a_res [2];
  logic        a_eq [2], a_slt [2];
  logic        rv [2], rid [2], r_eq [2], r_slt [2], busy [2];
  logic [31:0] rres [2];

  // reference model state
  bit          m_inflight [2];
  int          m_ready_at [2];
  logic [33:0] m_exp [2];
  req_t        m_cmd [2];
  logic        m_id [2];
  logic        m_last [2];
  bit          g [2][2];
  int          rsp_seen [2][2];
  int          rdy1_seen [2];
  int          cyc, tests, fails;

  function automatic logic [33:0] alu_f(input logic [2:0] opsel, input logic sub, input logic uns,
                                        input logic arith, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        lt;
    lt = uns ? (a < b) : ($signed(a) < $signed(b));
    case (opsel)
      3'b000:  r = sub ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, lt};
      3'b011:  r = {31'd0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = arith ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return {r, a == b, lt};
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    alu_share_arbiter #(.FAIR((k == 0) ? 1 : 0)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req0_valid(rq[k][0].valid), .i_req0_opsel(rq[k][0].opsel), .i_req0_sub(rq[k][0].sub),
      .i_req0_unsigned(rq[k][0].uns), .i_req0_arith(rq[k][0].arith),
      .i_req0_op1(rq[k][0].op1), .i_req0_op2(rq[k][0].op2), .o_req0_ready(rdy0[k]),
      .i_req1_valid(rq[k][1].valid), .i_req1_opsel(rq[k][1].opsel), .i_req1_sub(rq[k][1].sub),
      .i_req1_unsigned(rq[k][1].uns), .i_req1_arith(rq[k][1].arith),
      .i_req1_op1(rq[k][1].op1), .i_req1_op2(rq[k][1].op2), .o_req1_ready(rdy1[k]),
      .o_alu_opsel(a_opsel[k]), .o_alu_sub(a_sub[k]), .o_alu_unsigned(a_uns[k]),
      .o_alu_arith(a_arith[k]), .o_alu_op1(a_op1[k]), .o_alu_op2(a_op2[k]),
      .i_alu_result(a_res[k]), .i_alu_eq(a_eq[k]), .i_alu_slt(a_slt[k]),
      .o_rsp_valid(rv[k]), .o_rsp_id(rid[k]), .o_rsp_result(rres[k]),
      .o_rsp_eq(r_eq[k]), .o_rsp_slt(r_slt[k]), .i_rsp_ready(rsp_ready[k]), .o_busy(busy[k])
    );
    assign {a_res[k], a_eq[k], a_slt[k]} =
      alu_f(a_opsel[k], a_sub[k], a_uns[k], a_arith[k], a_op1[k], a_op2[k]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.valid = ($urandom_range(0, 2) != 0);
    r.opsel = 3'($urandom_range(0, 7));
    r.sub   = 1'($urandom_range(0, 1));
    r.uns   = 1'($urandom_range(0, 1));
    r.arith = 1'($urandom_range(0, 1));
    r.op1   = $urandom;
    r.op2   = ($urandom_range(0, 3) == 0) ? r.op1 : $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_inflight[k] = 1'b0;
      m_last[k]     = 1'b1;
      m_cmd[k]      = '0;
      g[k][0]       = 1'b0;
      g[k][1]       = 1'b0;
    end
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_ready0[%0d]", k), 32'(rdy0[k]), 32'd0);
    chk($sformatf("rst_ready1[%0d]", k), 32'(rdy1[k]), 32'd0);
    chk($sformatf("rst_busy[%0d]", k), 32'(busy[k]), 32'd0);
    chk($sformatf("rst_rsp_valid[%0d]", k), 32'(rv[k]), 32'd0);
    chk($sformatf("rst_rsp_id[%0d]", k), 32'(rid[k]), 32'd0);
    chk($sformatf("rst_rsp_result[%0d]", k), rres[k], 32'd0);
    chk($sformatf("rst_rsp_flags[%0d]", k), 32'({r_eq[k], r_slt[k]}), 32'd0);
    chk($sformatf("rst_alu_ctl[%0d]", k), 32'({a_opsel[k], a_sub[k], a_uns[k], a_arith[k]}), 32'd0);
    chk($sformatf("rst_alu_op1[%0d]", k), a_op1[k], 32'd0);
    chk($sformatf("rst_alu_op2[%0d]", k), a_op2[k], 32'd0);
  endtask

  // compare one instance against the reference for the current cycle, then advance the reference
  task automatic check_update(input int k);
    bit exp_rv, hs, ok;
    int win;
    exp_rv = m_inflight[k] && (cyc >= m_ready_at[k]);
    hs     = exp_rv && rsp_ready[k];
    ok     = !m_inflight[k] || hs;
    win    = -1;
    if (ok && rq[k][0].valid && rq[k][1].valid) win = (k == 0) ? (m_last[k] ? 0 : 1) : 0;
    else if (ok && rq[k][0].valid) win = 0;
    else if (ok && rq[k][1].valid) win = 1;
    chk($sformatf("ready0[%0d]@%0d", k, cyc), 32'(rdy0[k]), 32'(win == 0));
    chk($sformatf("ready1[%0d]@%0d", k, cyc), 32'(rdy1[k]), 32'(win == 1));
    chk($sformatf("busy[%0d]@%0d", k, cyc), 32'(busy[k]), 32'(m_inflight[k]));
    chk($sformatf("rsp_valid[%0d]@%0d", k, cyc), 32'(rv[k]), 32'(exp_rv));
    if (exp_rv) begin
      chk($sformatf("rsp_id[%0d]@%0d", k, cyc), 32'(rid[k]), 32'(m_id[k]));
      chk($sformatf("rsp_result[%0d]@%0d", k, cyc), rres[k], m_exp[k][33:2]);
      chk($sformatf("rsp_eq[%0d]@%0d", k, cyc), 32'(r_eq[k]), 32'(m_exp[k][1]));
      chk($sformatf("rsp_slt[%0d]@%0d", k, cyc), 32'(r_slt[k]), 32'(m_exp[k][0]));
    end
    chk($sformatf("alu_ctl[%0d]@%0d", k, cyc), 32'({a_opsel[k], a_sub[k], a_uns[k], a_arith[k]}),
        32'({m_cmd[k].opsel, m_cmd[k].sub, m_cmd[k].uns, m_cmd[k].arith}));
    chk($sformatf("alu_op1[%0d]@%0d", k, cyc), a_op1[k], m_cmd[k].op1);
    chk($sformatf("alu_op2[%0d]@%0d", k, cyc), a_op2[k], m_cmd[k].op2);
    if (rv[k] === 1'b1 && rsp_ready[k]) begin
      if (rid[k] === 1'b1) rsp_seen[k][1]++;
      else rsp_seen[k][0]++;
    end
    if (rdy1[k] === 1'b1) rdy1_seen[k]++;
    if (hs) m_inflight[k] = 1'b0;
    g[k][0] = (win == 0);
    g[k][1] = (win == 1);
    if (win >= 0) begin
      m_inflight[k] = 1'b1;
      m_cmd[k]      = rq[k][win];
      m_id[k]       = (win == 1);
      m_last[k]     = (win == 1);
      m_ready_at[k] = cyc + 2;
      m_exp[k]      = alu_f(rq[k][win].opsel, rq[k][win].sub, rq[k][win].uns, rq[k][win].arith,
                            rq[k][win].op1, rq[k][win].op2);
    end
  endtask

  task automatic tick();
    #1;
    check_update(0);
    check_update(1);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rq[k][0] = '0; rq[k][1] = '0; rsp_ready[k] = 1'b0;
      rsp_seen[k][0] = 0; rsp_seen[k][1] = 0; rdy1_seen[k] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;

    // single add on the round-robin instance
    rq[0][0] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7};
    rsp_ready[0] = 1'b1;
    #1 chk("add_ready_same_cycle", 32'(rdy0[0]), 32'd1);
    tick();
    rq[0][0].valid = 1'b0;
    tick();
    chk("add_rsp_valid", 32'(rv[0]), 32'd1);
    chk("add_rsp_id", 32'(rid[0]), 32'd0);
    chk("add_result", rres[0], 32'd12);
    chk("add_eq", 32'(r_eq[0]), 32'd0);
    chk("add_slt", 32'(r_slt[0]), 32'd1);
    tick();
    tick();

    // round-robin with both requesters continuously valid
    rsp_seen[0][0] = 0; rsp_seen[0][1] = 0;
    for (int n = 0; n < 2; n++) begin
      rq[0][n] = rand_req();
      rq[0][n].valid = 1'b1;
    end
    repeat (8) begin
      tick();
      for (int n = 0; n < 2; n++) if (g[0][n]) begin
        rq[0][n] = rand_req();
        rq[0][n].valid = 1'b1;
      end
    end
    rq[0][0].valid = 1'b0;
    rq[0][1].valid = 1'b0;
    tick();
    tick();
    chk("rr_rsp_id0", rsp_seen[0][0], 32'd2);
    chk("rr_rsp_id1", rsp_seen[0][1], 32'd2);

    // fixed priority on instance 1
    rsp_ready[1] = 1'b1;
    rsp_seen[1][0] = 0; rsp_seen[1][1] = 0; rdy1_seen[1] = 0;
    for (int n = 0; n < 2; n++) begin
      rq[1][n] = rand_req();
      rq[1][n].valid = 1'b1;
    end
    repeat (12) begin
      tick();
      for (int n = 0; n < 2; n++) if (g[1][n]) begin
        rq[1][n] = rand_req();
        rq[1][n].valid = 1'b1;
      end
    end
    rq[1][0].valid = 1'b0;
    rq[1][1].valid = 1'b0;
    tick();
    tick();
    chk("prio_rsp_id0", rsp_seen[1][0], 32'd6);
    chk("prio_rsp_id1", rsp_seen[1][1], 32'd0);
    chk("prio_ready1_seen", rdy1_seen[1], 32'd0);

    // backpressure with req1 (sltu) waiting
    rsp_ready[0] = 1'b0;
    rq[0][0] = '{1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 32'd3, 32'd10};
    tick();
    rq[0][0].valid = 1'b0;
    rq[0][1] = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1};
    tick();
    repeat (5) begin
      #1;
      chk("bp_ready1_low", 32'(rdy1[0]), 32'd0);
      chk("bp_rsp_valid", 32'(rv[0]), 32'd1);
      chk("bp_rsp_held", rres[0], 32'hFFFF_FFF9);
      tick();
    end
    rsp_ready[0] = 1'b1;
    #1 chk("bp_grant_on_hs", 32'(rdy1[0]), 32'd1);
    tick();
    rq[0][1].valid = 1'b0;
    tick();
    chk("bp_rsp_id", 32'(rid[0]), 32'd1);
    chk("bp_sltu_result", rres[0], 32'd0);
    chk("bp_sltu_slt", 32'(r_slt[0]), 32'd0);
    tick();
    tick();

    // arithmetic shift, then an equal-operand command back to back
    rq[0][1] = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4};
    tick();
    rq[0][1] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h1234_5678};
    tick();
    chk("sra_result", rres[0], 32'hF800_0000);
    tick();
    rq[0][1].valid = 1'b0;
    tick();
    chk("eq_rsp_valid", 32'(rv[0]), 32'd1);
    chk("eq_flag", 32'(r_eq[0]), 32'd1);
    chk("eq_result", rres[0], 32'h2468_ACF0);
    tick();
    tick();

    // reset while both instances are in EXEC
    rq[0][0] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2};
    rq[1][0] = rq[0][0];
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    chk_reset(1);
    model_reset();
    rq[0][1] = '{1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 32'h0F0F_0F0F, 32'hFFFF_0000};
    @(posedge clk);
    #1;
    chk_reset(0);
    rst_n = 1'b1;
    rq[1][0].valid = 1'b0;
    #1 chk("rst_first_tie", 32'(rdy0[0]), 32'd1);
    tick();
    rq[0][0].valid = 1'b0;
    tick();
    tick();
    rq[0][1].valid = 1'b0;
    repeat (3) tick();

    // randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      g[k][0] = 1'b0;
      g[k][1] = 1'b0;
    end
    repeat (400) begin
      for (int k = 0; k < 2; k++) begin
        for (int n = 0; n < 2; n++) if (g[k][n] || !rq[k][n].valid) rq[k][n] = rand_req();
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      rq[k][0].valid = 1'b0;
      rq[k][1].valid = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
